// File: rtl/vram_painter_pkg.sv
// vram_painter_pkg
//   Shared types for the VRAM painter: the touch record delivered by the
//   touch controller, the painter state encoding, the clipped brush window
//   and the clipping helpers used when a stamp is accepted.
//   No ports (package).
package vram_painter_pkg;

    localparam int COORD_W = 16;

    typedef logic [COORD_W-1:0] coord_t;

    // One touch channel: valid flag plus panel coordinates in pixels.
    typedef struct packed {
        logic   valid;
        coord_t x;
        coord_t y;
    } touch_t;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_STAMP = 2'd2
    } state_e;

    // Inclusive brush window after clipping to the screen.
    typedef struct packed {
        coord_t x0;
        coord_t x1;
        coord_t y0;
        coord_t y1;
    } win_t;

    // Lower edge c-r, floored at 0 without ever wrapping below zero.
    function automatic coord_t clip_lo(input coord_t c, input coord_t r);
        coord_t res;
        if (c >= r) begin
            res = c - r;
        end else begin
            res = {COORD_W{1'b0}};
        end
        return res;
    endfunction

    // Upper edge c+r, computed one bit wider and capped at lim.
    function automatic coord_t clip_hi(input coord_t c, input coord_t r, input coord_t lim);
        logic [COORD_W:0] sum;
        coord_t           res;
        sum = {1'b0, c} + {1'b0, r};
        if (sum > {1'b0, lim}) begin
            res = lim;
        end else begin
            res = sum[COORD_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/vram_painter_arb.sv
// rr_arbiter
//   Round-robin selection among N request lines. The pointer names the
//   channel with highest priority; after a channel is served the pointer
//   moves to the channel following it.
//   Ports: clk, rst (sync, active-high), req[N], advance + adv_idx (served
//   channel), grant_valid / grant_idx (combinational choice this cycle).
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [PW-1:0] adv_idx,
    output logic          grant_valid,
    output logic [PW-1:0] grant_idx
);

    localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] cand_s;

    // Scan once around the ring starting at the pointer; first request wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = ptr_q;
        cand_s      = ptr_q;
        for (int i = 0; i < N; i++) begin
            grant_idx   = (!grant_valid && req[cand_s]) ? cand_s : grant_idx;
            grant_valid = grant_valid | req[cand_s];
            cand_s      = (cand_s == LAST_IDX) ? {PW{1'b0}} : cand_s + PW'(1'b1);
        end
    end

    // Next pointer: channel after the one just served.
    always_comb begin
        if (advance) begin
            if (adv_idx == LAST_IDX) begin
                ptr_d = {PW{1'b0}};
            end else begin
                ptr_d = adv_idx + PW'(1'b1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= {PW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vram_painter.sv
// vram_painter
//   Paints square brush stamps into a linear VRAM from several touch
//   channels and clears the whole screen on reset or on request.
//   Ports: clk, rst (sync, active-high); touch[N_TOUCH] (valid,x,y);
//   clear_req (1-cycle pulse); draw_color, bg_color, brush_r;
//   vram_wr_ena / vram_wr_addr (y*W+x) / vram_wr_data (registered);
//   busy (registered, high while clearing or stamping).
module vram_painter
    import vram_painter_pkg::*;
#(
    parameter  int DISPLAY_WIDTH  = 240,
    parameter  int DISPLAY_HEIGHT = 320,
    parameter  int COLOR_W        = 16,
    parameter  int N_TOUCH        = 2,
    parameter  int MAX_BRUSH_R    = 3,
    localparam int L              = DISPLAY_WIDTH * DISPLAY_HEIGHT,
    localparam int AW             = $clog2(L),
    localparam int RW             = (MAX_BRUSH_R > 0) ? $clog2(MAX_BRUSH_R + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  touch_t             touch [N_TOUCH],
    input  logic               clear_req,
    input  logic [COLOR_W-1:0] draw_color,
    input  logic [COLOR_W-1:0] bg_color,
    input  logic [RW-1:0]      brush_r,
    output logic               vram_wr_ena,
    output logic [AW-1:0]      vram_wr_addr,
    output logic [COLOR_W-1:0] vram_wr_data,
    output logic               busy
);

    localparam int             PW      = (N_TOUCH > 1) ? $clog2(N_TOUCH) : 1;
    localparam logic [AW-1:0]  CNT_TOP = AW'(L - 1);
    localparam coord_t         W_C     = coord_t'(DISPLAY_WIDTH);
    localparam coord_t         H_C     = coord_t'(DISPLAY_HEIGHT);
    localparam coord_t         X_MAX   = coord_t'(DISPLAY_WIDTH - 1);
    localparam coord_t         Y_MAX   = coord_t'(DISPLAY_HEIGHT - 1);
    localparam coord_t         R_MAX   = coord_t'(MAX_BRUSH_R);

    state_e             state_q, state_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [COLOR_W-1:0] bg_q, bg_d;
    logic [COLOR_W-1:0] col_q, col_d;
    coord_t             row_x0_q, row_x0_d;
    coord_t             x1_q, x1_d;
    coord_t             y1_q, y1_d;
    coord_t             cur_x_q, cur_x_d;
    coord_t             cur_y_q, cur_y_d;
    logic [PW-1:0]      chan_q, chan_d;
    coord_t             last_x_q [N_TOUCH];
    coord_t             last_x_d [N_TOUCH];
    coord_t             last_y_q [N_TOUCH];
    coord_t             last_y_d [N_TOUCH];
    logic [N_TOUCH-1:0] last_vld_q, last_vld_d;
    logic               wr_ena_q, wr_ena_d;
    logic [AW-1:0]      wr_addr_q, wr_addr_d;
    logic [COLOR_W-1:0] wr_data_q, wr_data_d;
    logic               busy_q, busy_d;

    logic [N_TOUCH-1:0] req_s;
    logic               grant_valid_s;
    logic [PW-1:0]      grant_idx_s;
    logic               advance_s;
    logic [PW-1:0]      adv_idx_s;
    coord_t             sel_x_s, sel_y_s;
    coord_t             r_ext_s, r_s;
    win_t               win_s;
    logic               off_s, same_s;
    logic [AW-1:0]      pixel_addr_s;

    // Request vector straight from the live valid flags.
    always_comb begin
        for (int i = 0; i < N_TOUCH; i++) begin
            req_s[i] = touch[i].valid;
        end
    end

    rr_arbiter #(.N(N_TOUCH)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (req_s),
        .advance     (advance_s),
        .adv_idx     (adv_idx_s),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Selected touch, saturated radius, clipped window and filters.
    always_comb begin
        sel_x_s  = touch[grant_idx_s].x;
        sel_y_s  = touch[grant_idx_s].y;
        r_ext_s  = coord_t'(brush_r);
        r_s      = (r_ext_s > R_MAX) ? R_MAX : r_ext_s;
        win_s.x0 = clip_lo(sel_x_s, r_s);
        win_s.x1 = clip_hi(sel_x_s, r_s, X_MAX);
        win_s.y0 = clip_lo(sel_y_s, r_s);
        win_s.y1 = clip_hi(sel_y_s, r_s, Y_MAX);
        off_s    = (sel_x_s >= W_C) || (sel_y_s >= H_C);
        same_s   = last_vld_q[grant_idx_s] && (last_x_q[grant_idx_s] == sel_x_s)
                   && (last_y_q[grant_idx_s] == sel_y_s);
        // Linear address of the current stamp pixel, kept at AW bits.
        pixel_addr_s = AW'(cur_y_q) * AW'(DISPLAY_WIDTH) + AW'(cur_x_q);
        adv_idx_s    = (state_q == S_STAMP) ? chan_q : grant_idx_s;
    end

    // Painter FSM: next state, datapath and next registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bg_d      = bg_q;
        col_d     = col_q;
        row_x0_d  = row_x0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        chan_d    = chan_q;
        last_x_d  = last_x_q;
        last_y_d  = last_y_q;
        wr_ena_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        advance_s = 1'b0;
        // Lifting a finger forgets its last stamped point.
        for (int i = 0; i < N_TOUCH; i++) begin
            last_vld_d[i] = last_vld_q[i] & touch[i].valid;
        end
        case (state_q)
            S_CLEAR: begin
                wr_ena_d   = 1'b1;
                wr_addr_d  = cnt_q;
                last_vld_d = {N_TOUCH{1'b0}};
                // The first clear write samples bg_color; the rest reuse it.
                if (cnt_q == CNT_TOP) begin
                    wr_data_d = bg_color;
                    bg_d      = bg_color;
                end else begin
                    wr_data_d = bg_q;
                end
                if (cnt_q == {AW{1'b0}}) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - AW'(1'b1);
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = CNT_TOP;
                end else if (grant_valid_s) begin
                    if (off_s || same_s) begin
                        // Rejected touches still pass the turn on.
                        advance_s = 1'b1;
                    end else begin
                        state_d                  = S_STAMP;
                        row_x0_d                 = win_s.x0;
                        x1_d                     = win_s.x1;
                        y1_d                     = win_s.y1;
                        cur_x_d                  = win_s.x0;
                        cur_y_d                  = win_s.y0;
                        col_d                    = draw_color;
                        chan_d                   = grant_idx_s;
                        last_x_d[grant_idx_s]    = sel_x_s;
                        last_y_d[grant_idx_s]    = sel_y_s;
                        last_vld_d[grant_idx_s]  = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STAMP: begin
                wr_ena_d  = 1'b1;
                wr_addr_d = pixel_addr_s;
                wr_data_d = col_q;
                if (clear_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = CNT_TOP;
                end else if (cur_x_q != x1_q) begin
                    cur_x_d = cur_x_q + coord_t'(1'b1);
                end else if (cur_y_q != y1_q) begin
                    cur_x_d = row_x0_q;
                    cur_y_d = cur_y_q + coord_t'(1'b1);
                end else begin
                    state_d   = S_IDLE;
                    advance_s = 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = CNT_TOP;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; rst restarts the full-screen clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            cnt_q      <= CNT_TOP;
            bg_q       <= {COLOR_W{1'b0}};
            col_q      <= {COLOR_W{1'b0}};
            row_x0_q   <= {COORD_W{1'b0}};
            x1_q       <= {COORD_W{1'b0}};
            y1_q       <= {COORD_W{1'b0}};
            cur_x_q    <= {COORD_W{1'b0}};
            cur_y_q    <= {COORD_W{1'b0}};
            chan_q     <= {PW{1'b0}};
            for (int i = 0; i < N_TOUCH; i++) begin
                last_x_q[i] <= {COORD_W{1'b0}};
                last_y_q[i] <= {COORD_W{1'b0}};
            end
            last_vld_q <= {N_TOUCH{1'b0}};
            wr_ena_q   <= 1'b0;
            wr_addr_q  <= {AW{1'b0}};
            wr_data_q  <= {COLOR_W{1'b0}};
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bg_q       <= bg_d;
            col_q      <= col_d;
            row_x0_q   <= row_x0_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            chan_q     <= chan_d;
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
            last_vld_q <= last_vld_d;
            wr_ena_q   <= wr_ena_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    assign vram_wr_ena  = wr_ena_q;
    assign vram_wr_addr = wr_addr_q;
    assign vram_wr_data = wr_data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vram_painter.sv
// tb_vram_painter
//   Directed bench for vram_painter on a 240x120 screen. A queue of
//   expected writes is built from the painting rules (clear sweep, clipped
//   row-major square); one process compares every DUT write against it.
module tb_vram_painter;
    import vram_painter_pkg::*;

    localparam int W  = 240;
    localparam int H  = 120;
    localparam int CW = 16;
    localparam int NT = 2;
    localparam int MR = 3;
    localparam int L  = W * H;
    localparam int AW = $clog2(L);
    localparam int RW = $clog2(MR + 1);

    logic          clk = 1'b0;
    logic          rst;
    touch_t        touch [NT];
    logic          clear_req;
    logic [CW-1:0] draw_color;
    logic [CW-1:0] bg_color;
    logic [RW-1:0] brush_r;
    logic          vram_wr_ena;
    logic [AW-1:0] vram_wr_addr;
    logic [CW-1:0] vram_wr_data;
    logic          busy;

    vram_painter #(
        .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .COLOR_W(CW),
        .N_TOUCH(NT), .MAX_BRUSH_R(MR)
    ) dut (
        .clk(clk), .rst(rst), .touch(touch), .clear_req(clear_req),
        .draw_color(draw_color), .bg_color(bg_color), .brush_r(brush_r),
        .vram_wr_ena(vram_wr_ena), .vram_wr_addr(vram_wr_addr),
        .vram_wr_data(vram_wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  obs_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    // Expected writes of one square stamp, at most 'limit' of them.
    task automatic model_stamp(input int x, input int y, input int r, input int color, input int limit);
        int x0, x1, y0, y1, n;
        x0 = (x - r < 0) ? 0 : x - r;
        x1 = (x + r > W - 1) ? W - 1 : x + r;
        y0 = (y - r < 0) ? 0 : y - r;
        y1 = (y + r > H - 1) ? H - 1 : y + r;
        n  = 0;
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = x0; xx <= x1; xx++) begin
                if (n < limit) begin
                    exp_q.push_back('{addr: yy * W + xx, data: color});
                    n++;
                end
            end
        end
    endtask

    task automatic model_clear(input int bg);
        for (int a = L - 1; a >= 0; a--) begin
            exp_q.push_back('{addr: a, data: bg});
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic chk_log(input string name, input int lst[$]);
        int bad;
        bad = (obs_q.size() != lst.size()) ? 1 : 0;
        for (int i = 0; i < lst.size() && bad == 0; i++) begin
            if (obs_q[i] != lst[i]) bad = 1;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL %s: got %0d writes %p, required %p", name, obs_q.size(), obs_q, lst);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget);
        n_vec++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: timeout with %0d writes outstanding, busy=%0b, required 0 and 0",
                     name, exp_q.size(), busy);
        end
    endtask

    task automatic set_touch(input int ch, input logic v, input int x, input int y);
        touch[ch] = '{valid: v, x: 16'(x), y: 16'(y)};
    endtask

    // Compare every DUT write with the head of the expected queue.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (vram_wr_ena === 1'b1) begin
            obs_q.push_back(int'(vram_wr_addr));
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write_stream: got addr %0d data %04h, required no write",
                         vram_wr_addr, vram_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (int'(vram_wr_addr) != e.addr || int'(vram_wr_data) != e.data) begin
                    n_err++;
                    $display("FAIL write_stream: got addr %0d data %04h, required addr %0d data %04h",
                             vram_wr_addr, vram_wr_data, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lst[$];
        rst        = 1'b1;
        clear_req  = 1'b0;
        draw_color = 16'h0000;
        bg_color   = 16'h1234;
        brush_r    = 2'd0;
        for (int i = 0; i < NT; i++) set_touch(i, 1'b0, 0, 0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_wr_ena", int'(vram_wr_ena), 0);
        chk("reset_wr_addr", int'(vram_wr_addr), 0);
        chk("reset_wr_data", int'(vram_wr_data), 0);
        chk("reset_busy", int'(busy), 1);

        // Full clear after reset release, first write one cycle later
        model_clear(32'h1234);
        rst = 1'b0;
        @(posedge clk); #2;
        chk("first_clear_ena", int'(vram_wr_ena), 1);
        chk("first_clear_addr", int'(vram_wr_addr), L - 1);
        wait_drain("reset_clear", L + 20);
        chk("idle_busy", int'(busy), 0);

        // Stamp r=1 at (10,20) on channel 0, with latency check
        obs_q.delete();
        brush_r    = 2'd1;
        draw_color = 16'hF800;
        set_touch(0, 1'b1, 10, 20);
        model_stamp(10, 20, 1, 32'hF800, 1000);
        @(posedge clk); #2;
        chk("latency_edge_k_no_write", int'(vram_wr_ena), 0);
        chk("busy_after_accept", int'(busy), 1);
        @(posedge clk); #2;
        chk("latency_edge_k1_write", int'(vram_wr_ena), 1);
        chk("latency_edge_k1_addr", int'(vram_wr_addr), 4569);
        wait_drain("stamp_10_20", 50);
        lst = '{4569, 4570, 4571, 4809, 4810, 4811, 5049, 5050, 5051};
        chk_log("stamp_10_20_addrs", lst);
        repeat (5) @(negedge clk);
        set_touch(0, 1'b0, 10, 20);
        repeat (2) @(negedge clk);

        // Corner clip at (0,0) on channel 1
        obs_q.delete();
        draw_color = 16'h07E0;
        set_touch(1, 1'b1, 0, 0);
        model_stamp(0, 0, 1, 32'h07E0, 1000);
        wait_drain("stamp_0_0", 50);
        lst = '{0, 1, 240, 241};
        chk_log("stamp_0_0_addrs", lst);
        repeat (3) @(negedge clk);
        set_touch(1, 1'b0, 0, 0);
        repeat (2) @(negedge clk);

        // Two held fingers: one stamp each, then dedupe silence
        obs_q.delete();
        brush_r    = 2'd0;
        draw_color = 16'h001F;
        set_touch(0, 1'b1, 5, 5);
        set_touch(1, 1'b1, 100, 100);
        model_stamp(5, 5, 0, 32'h001F, 1000);
        model_stamp(100, 100, 0, 32'h001F, 1000);
        wait_drain("two_fingers", 50);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("held_no_busy", int'(busy), 0);
        end
        lst = '{1205, 24100};
        chk_log("two_fingers_addrs", lst);

        // Moving finger stamps again; lift and re-press at same spot too
        obs_q.delete();
        set_touch(0, 1'b1, 6, 5);
        model_stamp(6, 5, 0, 32'h001F, 1000);
        wait_drain("moved_finger", 50);
        set_touch(0, 1'b0, 6, 5);
        @(negedge clk);
        set_touch(0, 1'b1, 6, 5);
        model_stamp(6, 5, 0, 32'h001F, 1000);
        wait_drain("repressed_finger", 50);
        repeat (5) @(negedge clk);
        lst = '{1206, 1206};
        chk_log("dedupe_release_addrs", lst);
        set_touch(0, 1'b0, 0, 0);
        set_touch(1, 1'b0, 0, 0);
        repeat (2) @(negedge clk);

        // Off-screen touches: no write, busy stays low
        brush_r = 2'd1;
        set_touch(0, 1'b1, 240, 10);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("offscreen_x_busy", int'(busy), 0);
        end
        set_touch(0, 1'b1, 5, 120);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("offscreen_y_busy", int'(busy), 0);
        end
        set_touch(0, 1'b0, 0, 0);
        @(negedge clk);

        // Bottom-right corner clip with r=2
        brush_r    = 2'd2;
        draw_color = 16'h7777;
        set_touch(0, 1'b1, 239, 119);
        model_stamp(239, 119, 2, 32'h7777, 1000);
        wait_drain("stamp_corner_br", 50);
        set_touch(0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);

        // Clear aborts a stamp after its 3rd write; later clear_req ignored
        bg_color   = 16'h0F0F;
        brush_r    = 2'd3;
        draw_color = 16'hABCD;
        set_touch(0, 1'b1, 50, 50);
        model_stamp(50, 50, 3, 32'hABCD, 3);
        model_clear(32'h0F0F);
        repeat (3) @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        set_touch(0, 1'b0, 0, 0);
        repeat (5) @(negedge clk);
        bg_color = 16'hFFFF;
        repeat (100) @(negedge clk);
        chk("busy_during_clear", int'(busy), 1);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        wait_drain("clear_abort", L + 50);
        chk("idle_after_abort_clear", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vram_painter.md
VRAM_PAINTER -- requirements
Module: vram_painter

Interface
REQ-001 Parameter DISPLAY_WIDTH, default 240, pixels per row.
REQ-002 Parameter DISPLAY_HEIGHT, default 320, rows.
REQ-003 Parameter COLOR_W, default 16, VRAM word width.
REQ-004 Parameter N_TOUCH, default 2, number of touch channels.
REQ-005 Parameter MAX_BRUSH_R, default 3, largest brush radius.
REQ-006 Derived L = DISPLAY_WIDTH*DISPLAY_HEIGHT and AW = $clog2(L).
REQ-007 Reset rst, synchronous, active-high; clock clk.
REQ-008 clk  in  1  system clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 touch  in  touch_t[N_TOUCH]  per-channel valid, x, y.
REQ-011 clear_req  in  1  single-cycle request to fill the screen with bg_color.
REQ-012 draw_color  in  COLOR_W  brush colour, sampled when a stamp starts.
REQ-013 bg_color  in  COLOR_W  clear colour, sampled at clear start.
REQ-014 brush_r  in  $clog2(MAX_BRUSH_R+1)  brush radius; side = 2*brush_r+1; values above MAX_BRUSH_R saturate.
REQ-015 vram_wr_ena  out  1  VRAM write strobe.
REQ-016 vram_wr_addr  out  AW  write address = y*DISPLAY_WIDTH + x.
REQ-017 vram_wr_data  out  COLOR_W  write data.
REQ-018 busy  out  1  high in S_CLEAR or S_STAMP.

Function
REQ-019 States: S_CLEAR, S_IDLE, S_STAMP; all outputs registered; at most one write per cycle.
REQ-020 S_CLEAR: write bg_color at addresses L-1 down to 0, one per cycle, exactly L writes, then S_IDLE.
REQ-021 S_IDLE: the round-robin arbiter selects one valid channel per cycle, with priority starting at the channel after the last one served.
REQ-022 Discard a selected touch with x >= DISPLAY_WIDTH or y >= DISPLAY_HEIGHT; no write occurs.
REQ-023 Skip a touch whose (x,y) equals that channel's last stamped coordinate (held-finger dedupe); the last-coordinate record is invalidated on that channel's valid deassertion and on clear.
REQ-024 On accept, latch the colour and the clipped window x0=max(x-r,0), x1=min(x+r,W-1), y0=max(y-r,0), y1=min(y+r,H-1); enter S_STAMP.
REQ-025 S_STAMP: write draw_color row-major (y0..y1 outer, x0..x1 inner), one per cycle; then return to S_IDLE and advance the round-robin pointer.
REQ-026 Latency: a touch sampled at edge k produces its first write visible after edge k+1.
REQ-027 Address arithmetic is done at AW bits with no truncation; clipping is done on signed or extended values so x-r never wraps.
REQ-028 clear_req in S_IDLE or S_STAMP aborts any stamp after the current write and enters S_CLEAR on the next edge; clear_req in S_CLEAR is ignored.
REQ-029 clear_req and an accept in the same S_IDLE cycle: clear wins and the touch is dropped.
REQ-030 Touches arriving during S_CLEAR or S_STAMP are not queued; only live valid inputs are sampled in S_IDLE.

Reset
REQ-031 rst forces S_CLEAR with counter L-1, vram_wr_ena=0, vram_wr_addr=0, vram_wr_data=0, busy=1, round-robin pointer 0, and all dedupe records invalid.
REQ-032 The first clear write occurs in the cycle after rst deasserts.
REQ-033 rst mid-stamp or mid-clear restarts the full clear.

Structure
REQ-034 The state enum and the window-bounds struct go in package vram_painter_pkg; touch_t and colour types come from the existing ft6206 and ili9341 define files.
REQ-035 Round-robin selection is sub-module rr_arbiter (N_TOUCH requests, registered last-grant pointer, advance input).

Verification (W=240, H=320, L=76800)
REQ-036 Release rst -> 76800 consecutive writes of bg_color, addresses 76799..0, then busy=0.
REQ-037 brush_r=1, touch0 at (10,20) -> writes 4569, 4570, 4571, 4809, 4810, 4811, 5049, 5050, 5051 in that order.
REQ-038 brush_r=1, touch0 at (0,0) -> exactly 4 writes: 0, 1, 240, 241.
REQ-039 brush_r=0, touch0 at (5,5) and touch1 at (100,100) both valid and held -> writes 1205 then 24100, then no further writes while both are held.
REQ-040 brush_r=3, clear_req pulsed on the 3rd stamp write -> stamp stops, then 76800 clear writes.
REQ-041 touch0 at (240,10) -> no write and busy stays 0.
